// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared encodings and shadow-entry layout for the hazard controller
package hazard_controller_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hz_state_t;

    // Flag bits are {valid, wr, ld}; the register tags follow them.
    localparam int SH_FLAG_W = 3;

    // EX keeps the full entry, MEM drops the source tags, WB only needs the write tag.
    function automatic int ex_entry_w(input int aw);
        return SH_FLAG_W + 3 * aw;
    endfunction

    function automatic int mem_entry_w(input int aw);
        return SH_FLAG_W + aw;
    endfunction

    function automatic int wb_entry_w(input int aw);
        return SH_FLAG_W - 1 + aw;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// rtl/hazard_shadow_stage.sv - one shadow pipeline register of destination/source tags
module hazard_shadow_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // A flushed entry is all-zero, which reads as invalid with rd = 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forwarding control for the 5-stage RV32I pipeline
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_esc_reg_n,
    input  logic                  id_lw,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  stall_clr,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_flush,
    output logic                  pc_sel,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int AW  = REG_ADDR_W;
    localparam int EXW = ex_entry_w(AW);
    localparam int MW  = mem_entry_w(AW);
    localparam int WW  = wb_entry_w(AW);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [EXW-1:0] id_entry, ex_entry;
    logic [MW-1:0]  mem_d, mem_entry;
    logic [WW-1:0]  wb_d, wb_entry;

    logic          ex_valid, ex_wr, ex_ld;
    logic [AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic          mem_valid, mem_wr, mem_ld;
    logic [AW-1:0] mem_rd;
    logic          wb_valid, wb_wr;
    logic [AW-1:0] wb_rd;

    hz_state_t state, state_nxt;
    logic      frozen;
    logic      load_use;

    assign id_entry = {1'b1, ~id_esc_reg_n & (id_rd != '0), id_lw, id_rd, id_rs1, id_rs2};
    assign {ex_valid, ex_wr, ex_ld, ex_rd, ex_rs1, ex_rs2} = ex_entry;
    assign mem_d = {ex_valid, ex_wr, ex_ld, ex_rd};
    assign {mem_valid, mem_wr, mem_ld, mem_rd} = mem_entry;
    assign wb_d = {mem_valid, mem_wr, mem_rd};
    assign {wb_valid, wb_wr, wb_rd} = wb_entry;

    hazard_shadow_stage #(.W(EXW)) u_ex_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (idex_en),
        .flush   (idex_flush),
        .d       (id_entry),
        .q       (ex_entry)
    );

    hazard_shadow_stage #(.W(MW)) u_mem_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (exmem_en),
        .flush   (1'b0),
        .d       (mem_d),
        .q       (mem_entry)
    );

    hazard_shadow_stage #(.W(WW)) u_wb_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~frozen),
        .flush   (memwb_flush),
        .d       (wb_d),
        .q       (wb_entry)
    );

    assign load_use = ex_valid & ex_ld & ex_wr &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // The freeze is decided combinationally so a busy memory stalls in the same cycle.
    always_comb begin
        state_nxt   = state;
        frozen      = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        pc_sel      = 1'b0;

        if (state == RUN) begin
            if (mem_req && !mem_ready) begin
                state_nxt = FREEZE;
                frozen    = 1'b1;
            end
        end else begin
            if (mem_ready) begin
                state_nxt = RUN;
            end else begin
                frozen = 1'b1;
            end
        end

        if (!reset_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (frozen) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // A load sitting in MEM has no data yet, so it never forwards from EX/MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic          m_valid,
        input logic          m_wr,
        input logic          m_ld,
        input logic [AW-1:0] m_rd,
        input logic          w_valid,
        input logic          w_wr,
        input logic [AW-1:0] w_rd
    );
        if (m_valid && m_wr && !m_ld && (m_rd == rs)) begin
            return FWD_EXMEM;
        end else if (w_valid && w_wr && (w_rd == rs)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reset_n) begin
            fwd_a = fwd_sel(ex_rs1, mem_valid, mem_wr, mem_ld, mem_rd, wb_valid, wb_wr, wb_rd);
            fwd_b = fwd_sel(ex_rs2, mem_valid, mem_wr, mem_ld, mem_rd, wb_valid, wb_wr, wb_rd);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_esc_reg_n, id_lw;
    logic        ex_redirect, mem_req, mem_ready, stall_clr;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_flush, pc_sel;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_esc_reg_n (id_esc_reg_n),
        .id_lw        (id_lw),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .stall_clr    (stall_clr),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_flush  (memwb_flush),
        .pc_sel       (pc_sel),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic escn, input logic lw);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_esc_reg_n = escn;
        id_lw        = lw;
    endtask

    initial begin
        reset_n     = 1'b0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
        stall_clr   = 1'b0;
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        repeat (3) tick;
        reset_n = 1'b1;

        // reset asserted in the middle of a freeze
        mem_req = 1'b1;
        settle;
        check("freeze_comb_pc_en", 32'(pc_en), 0);
        tick;
        reset_n = 1'b0;
        settle;
        check("rst_enables", 32'({pc_en, ifid_en, idex_en, exmem_en}), 'h0);
        check("rst_flushes", 32'({ifid_flush, idex_flush, memwb_flush}), 'h7);
        check("rst_pc_sel", 32'(pc_sel), 0);
        check("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        mem_req = 1'b0;
        tick;
        reset_n = 1'b1;
        settle;
        check("post_rst_enables", 32'({pc_en, ifid_en, idex_en, exmem_en}), 'hF);
        check("post_rst_flushes", 32'({ifid_flush, idex_flush, memwb_flush}), 0);
        check("post_rst_fwd", 32'({fwd_a, fwd_b}), 0);
        tick;

        // load-use: LW x5 ; ADD x6,x5,x1
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1);
        settle;
        check("lw_issue_pc_en", 32'(pc_en), 1);
        tick;
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
        settle;
        check("lu_pc_en", 32'(pc_en), 0);
        check("lu_ifid_en", 32'(ifid_en), 0);
        check("lu_idex_flush", 32'(idex_flush), 1);
        check("lu_exmem_en", 32'(exmem_en), 1);
        tick;
        mem_req   = 1'b1;
        mem_ready = 1'b1;
        settle;
        check("lu_one_bubble", 32'(pc_en), 1);
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        tick;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1);
        settle;
        check("lu_fwd_a_wb", 32'(fwd_a), 2);
        check("lu_fwd_b_rf", 32'(fwd_b), 0);
        tick;

        // fields name x7 but the instruction reads neither source
        set_id(5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        settle;
        check("unused_rs_no_stall", 32'(pc_en), 1);
        tick;
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        settle;
        check("load_in_mem_no_fwd", 32'({fwd_a, fwd_b}), 0);
        tick;

        // ALU chain: ADDI x3 ; ADDI x3 ; ADD x4,x3,x3 ; ADDI x0 ; ADD x9,x0,x4
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        settle;
        check("alu_no_stall_a", 32'(pc_en), 1);
        tick;
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        settle;
        check("alu_no_stall_b", 32'(pc_en), 1);
        tick;
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        settle;
        check("alu_fwd_a_mem_prio", 32'(fwd_a), 1);
        check("alu_fwd_b_mem_prio", 32'(fwd_b), 1);
        tick;
        set_id(5'd0, 5'd4, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        tick;
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        settle;
        check("x0_fwd_a", 32'(fwd_a), 0);
        check("x0_fwd_b_wb", 32'(fwd_b), 2);
        tick;

        // redirect beats load-use
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1);
        tick;
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
        ex_redirect = 1'b1;
        settle;
        check("redir_pc_sel", 32'(pc_sel), 1);
        check("redir_flushes", 32'({ifid_flush, idex_flush, memwb_flush}), 'h6);
        check("redir_enables", 32'({pc_en, ifid_en, idex_en, exmem_en}), 'hF);
        tick;

        // memory wait of 3 cycles with a pending redirect
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle;
            check("mw_frozen_enables", 32'({pc_en, ifid_en, idex_en, exmem_en}), 0);
            check("mw_frozen_memwb_flush", 32'(memwb_flush), 1);
            check("mw_redirect_held", 32'(pc_sel), 0);
            tick;
        end
        mem_ready = 1'b1;
        settle;
        check("mw_redirect_serviced", 32'({pc_sel, pc_en, ifid_flush, memwb_flush}), 'hE);
        check("mw_stall_cnt", 32'(stall_cnt), 4);
        tick;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
        ex_redirect = 1'b0;
        settle;
        check("mw_back_to_run", 32'(pc_en), 1);

        // counter saturation and clear
        stall_clr = 1'b1;
        tick;
        stall_clr = 1'b0;
        settle;
        check("cnt_cleared", 32'(stall_cnt), 0);
        mem_req = 1'b1;
        repeat (65535) tick;
        settle;
        check("cnt_full", 32'(stall_cnt), 'hFFFF);
        tick;
        tick;
        settle;
        check("cnt_saturates", 32'(stall_cnt), 'hFFFF);
        stall_clr = 1'b1;
        tick;
        settle;
        check("cnt_clr_priority", 32'(stall_cnt), 0);
        stall_clr = 1'b0;
        mem_req   = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB) that runs the merge-sort program.
- Keeps a shadow pipeline of destination-register tags for EX, MEM and WB.
- Detects load-use and control hazards, and freezes the pipeline while the multi-cycle data memory is busy.
- Drives every pipeline-register enable and flush, plus the EX-stage forwarding selects.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source indices of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- id_rd  in  REG_ADDR_W  destination index in ID.
- id_esc_reg_n  in  1  active-low register write from decode; 0 means the instruction writes rd.
- id_lw  in  1  ID instruction is a load.
- ex_redirect  in  1  taken BLT/BGE, JAL or JALR resolved in EX.
- mem_req  in  1  MEM stage holds a LW/SW access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_clr  in  1  synchronous clear of stall_cnt.
- pc_en, ifid_en, idex_en, exmem_en  out  1  pipeline-register enables.
- ifid_flush, idex_flush, memwb_flush  out  1  insert bubble into that register.
- pc_sel  out  1  1 selects the EX redirect target.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
- stall_cnt  out  CNT_W  cycles with pc_en = 0.

Behaviour:
- Reset while reset_n = 0, asynchronous:
  - state = RUN, all shadow entries invalid with rd = 0, stall_cnt = 0.
  - Outputs: every enable 0, every flush 1, pc_sel 0, fwd 00.
- Shadow entry contents: {valid, wr, ld, rd, rs1, rs2}. wr = valid & ~esc_reg_n & (rd != 0).
- Shadow advance rules:
  - EX loads the ID fields when idex_en = 1. It loads invalid when idex_flush = 1.
  - MEM loads EX when exmem_en = 1.
  - WB loads MEM when not frozen. It loads invalid when memwb_flush = 1.
- FSM has two states, RUN and FREEZE.
  - RUN -> FREEZE when mem_req & ~mem_ready.
  - FREEZE -> RUN when mem_ready.
  - Reset returns to RUN from any state.
- Freeze condition = (state == FREEZE & ~mem_ready) | (state == RUN & mem_req & ~mem_ready). It is combinational so the stall takes effect in the same cycle.
- While frozen:
  - pc_en, ifid_en, idex_en, exmem_en = 0, memwb_flush = 1.
  - Redirect and load-use are suppressed; ex_redirect stays asserted and is acted on in the first unfrozen cycle.
- Redirect (not frozen, ex_redirect = 1):
  - pc_sel = 1, ifid_flush = 1, idex_flush = 1, all enables 1.
  - Redirect has priority over load-use.
- Load-use (not frozen, no redirect): EX.valid & EX.ld & EX.wr, and (id_use_rs1 & id_rs1 == EX.rd) or (id_use_rs2 & id_rs2 == EX.rd).
  - pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = 1.
  - Exactly one bubble; the next cycle the load is in MEM and forwarding covers it.
- Otherwise all enables are 1 and all flushes are 0.
- Forwarding, from EX-stage rs fields, for each operand:
  - 01 if MEM.wr & MEM.rd == EX.rs and MEM is not a load.
  - else 10 if WB.wr & WB.rd == EX.rs.
  - else 00.
  - MEM has priority over WB. Index 0 never forwards.
- stall_cnt increments when pc_en = 0 and saturates at all-ones. stall_clr has priority over the increment.

Decomposition:
- Shared package holds: the FWD_RF / FWD_EXMEM / FWD_MEMWB encodings, the RUN / FREEZE state encoding, and the shadow-entry field widths.
- One sub-module is natural: hazard_shadow_stage, a single shadow pipeline register with enable and flush, instantiated three times.

Test Plan:
- Reset: hold reset_n = 0 mid-freeze -> all enables 0, flushes 1, stall_cnt 0. After release -> RUN, enables 1, fwd 00.
- Load-use: LW x5 then ADD x6,x5,x1 -> one cycle with pc_en = 0, idex_flush = 1. Next cycle fwd_a = 10. stall_cnt = 1.
- ALU chain: ADDI x3,x0,4; ADD x4,x3,x3 -> fwd_a = fwd_b = 01, no stall. Writes to x0 -> fwd 00.
- Redirect with load-use: ex_redirect = 1 while load-use condition is true -> pc_sel = 1, ifid_flush = idex_flush = 1, pc_en = 1.
- Memory wait: SW with mem_ready low for 3 cycles -> 3 frozen cycles with memwb_flush = 1. A concurrent ex_redirect is serviced on the 4th cycle. stall_cnt += 3.
- Counter: force 65 535 stall cycles -> stall_cnt holds 0xFFFF. stall_clr = 1 -> 0 next cycle.
